dmux_nway_reg: RTL
==================

DMUX_NWAY_REG -- requirements
Module: dmux_nway_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per transfer.
REQ-002 SHALL provide parameter NCH, default 4, number of output channels; legal values are powers of two, at least 2.
REQ-003 SHALL provide parameter SELW, default $clog2(NCH), selector width; it is derived from NCH and is never overridden.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, source offers a transfer.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts the offered transfer this cycle.
REQ-009 SHALL have port in_data, input, WIDTH bits, transfer payload.
REQ-010 SHALL have port sel, input, SELW bits, destination channel index for unicast.
REQ-011 SHALL have port bcast, input, 1 bit, 1 selects broadcast mode (all channels) and overrides sel.
REQ-012 SHALL have port out_valid, output, NCH bits, channel i holds a valid word.
REQ-013 SHALL have port out_ready, input, NCH bits, sink i consumes the word this cycle.
REQ-014 SHALL have port out_data, output, NCH*WIDTH bits; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port acc_cnt, output, 16 bits, count of accepted input transfers; wraps modulo 2^16.

Function
REQ-016 Each channel SHALL hold a one-entry register consisting of a valid bit and a WIDTH-bit data word.
REQ-017 Channel i SHALL be able to accept a word when !out_valid[i] | out_ready[i]; this is free(i).
REQ-018 In unicast mode (bcast=0), in_ready SHALL equal free(sel).
REQ-019 In broadcast mode (bcast=1), in_ready SHALL equal the AND of free(i) over all i.
REQ-020 in_ready SHALL be combinational from sel, bcast and out_ready, and SHALL NOT depend on in_valid.
REQ-021 Accept SHALL be in_valid & in_ready, sampled at the rising edge of clk.
REQ-022 On a unicast accept, channel sel SHALL load in_data and set out_valid[sel]=1 at that edge, giving 1-cycle latency; other channels are unaffected except by their own pops.
REQ-023 On a broadcast accept, every channel SHALL load in_data and set out_valid to all ones at the same edge.
REQ-024 Pop SHALL be out_valid[i] & out_ready[i]; a pop without a load on that channel clears out_valid[i] at the edge.
REQ-025 When a pop and a load occur on the same channel in the same cycle, the channel SHALL load the new word and keep out_valid[i]=1, sustaining full throughput of 1 word per cycle.
REQ-026 While out_valid[i]=1 and out_ready[i]=0, out_data for channel i SHALL remain stable.
REQ-027 When out_valid[i]=0, out_data for channel i SHALL retain the last loaded value.
REQ-028 When in_valid=1 and in_ready=0, the block SHALL perform no state change; the source holds its transfer.
REQ-029 out_ready[i] SHALL be ignored while out_valid[i]=0.
REQ-030 acc_cnt SHALL increment by 1 per accept, counting a broadcast as 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-031 Changing sel or bcast while in_valid=1 and in_ready=0 SHALL be legal; readiness is re-evaluated each cycle.

Reset
REQ-032 While reset=1, asynchronously: out_valid SHALL be 0, out_data SHALL be 0, and acc_cnt SHALL be 0.
REQ-033 A reset asserted mid-operation SHALL discard all held words, and no pop SHALL be reported afterwards.
REQ-034 The first accept SHALL be possible on the first rising edge after reset deassertion.

Verification
REQ-035 With NCH=4, WIDTH=8, after reset: drive in_valid=1, sel=2, in_data=0xA5 with all out_ready=0 -> next cycle out_valid=0100 and ch2 data=0xA5; in_ready for sel=2 reads 0 while in_ready for sel=0 reads 1.
REQ-036 Sweep sel 0..3 with data 0x10..0x13 and out_ready=1111 -> each word appears on the selected channel only, 1 cycle later; acc_cnt=4.
REQ-037 Broadcast 0x3C with ch1 full and out_ready[1]=0 -> in_ready=0 and nothing changes; raise out_ready[1] -> accept occurs, out_valid=1111, all channels hold 0x3C.
REQ-038 Unicast back-to-back on ch3 with out_ready[3]=1 continuously -> one word per cycle with no gaps and in_ready held at 1.
REQ-039 Assert reset asynchronously between edges while out_valid=1011 -> out_valid, out_data and acc_cnt read 0 immediately.
REQ-040 Perform 65537 accepts -> acc_cnt=0x0001.

Source files
------------

// File: rtl/dmux_nway_reg.sv
// One-to-N demultiplexer with a one-entry output register per channel.
// Supports unicast by sel or broadcast to all channels, with valid/ready handshakes.
module dmux_nway_reg #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [SELW-1:0]       sel,
   input  logic                  bcast,
   output logic [NCH-1:0]        out_valid,
   input  logic [NCH-1:0]        out_ready,
   output logic [NCH*WIDTH-1:0]  out_data,
   output logic [15:0]           acc_cnt
);

   logic [NCH-1:0]   free;
   logic [NCH-1:0]   load;
   logic [NCH-1:0]   pop;
   logic             accept;
   logic [WIDTH-1:0] data_q [NCH];

   // A channel can take a word when it is empty or its current word drains this cycle.
   // Readiness never looks at in_valid, so the source sees a stable in_ready.
   assign free     = ~out_valid | out_ready;
   assign in_ready = bcast ? (&free) : free[sel];
   assign accept   = in_valid & in_ready;
   assign pop      = out_valid & out_ready;

   // Each channel loads on its own accept; a load wins over a pop so throughput stays at one word per cycle.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign load[i] = accept & (bcast | (sel == SELW'(i)));
      assign out_data[i*WIDTH +: WIDTH] = data_q[i];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            out_valid[i] <= 1'b0;
            data_q[i]    <= '0;
         end else if (load[i]) begin
            out_valid[i] <= 1'b1;
            data_q[i]    <= in_data;
         end else if (pop[i]) begin
            out_valid[i] <= 1'b0;
         end
      end
   end

   // Broadcasts count once; the counter wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_cnt <= 16'h0000;
      end else if (accept) begin
         acc_cnt <= acc_cnt + 16'h0001;
      end
   end

endmodule
